// File: rtl/conv1d_par_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv1d_par_pkg                                            |
// | Function : Shared types, defaults and helpers for the 1-D            |
// |            convolution engine.                                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package conv1d_par_pkg;

    // Engine sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_K = 3'd1,
        MAC    = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Default geometry: kernel at word 0, inputs right after it, and the
    // remaining space split evenly between inputs and outputs.
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_MAX_KERNEL  = 8;
    localparam int DEF_NUM_WORDS   = 128;
    localparam int DEF_KERNEL_BASE = 0;
    localparam int DEF_IN_BASE     = DEF_MAX_KERNEL;
    localparam int DEF_OUT_BASE    = DEF_IN_BASE + (DEF_NUM_WORDS - DEF_MAX_KERNEL) / 2;

    // Accumulator sized so that MaxKernel (<= 8) full-scale products can
    // never overflow: 2*W product bits plus 3 growth bits.
    function automatic int acc_width(input int data_width);
        return 2 * data_width + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv1d_par_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv1d_par_mac                                            |
// | Function : Signed multiply-accumulate with arithmetic shift, optional |
// |            ReLU and saturation to the sample width.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module conv1d_par_mac
    import conv1d_par_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        acc_en_i,
    input  logic signed [DataWidth-1:0] sample_i,
    input  logic signed [DataWidth-1:0] weight_i,
    input  logic        [4:0]           shift_i,
    input  logic                        relu_en_i,
    output logic signed [DataWidth-1:0] result_o
);
    localparam int AccWidth = acc_width(DataWidth);
    localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] SatMin = ~SatMax;

    logic signed [2*DataWidth-1:0] product;
    logic signed [AccWidth-1:0]    product_ext;
    logic signed [AccWidth-1:0]    acc;
    logic signed [AccWidth-1:0]    shifted;
    logic signed [AccWidth-1:0]    clamped;

    assign product     = sample_i * weight_i;
    assign product_ext = $signed({{(AccWidth - 2*DataWidth){product[2*DataWidth-1]}}, product});

    // Accumulator: cleared on entry to each output, summed once per tap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc <= '0;
        end else if (clear_i) begin
            acc <= '0;
        end else if (acc_en_i) begin
            acc <= acc + product_ext;
        end
    end

    // Post-processing: floor shift, optional ReLU, then clamp to sample range
    always_comb begin
        shifted = acc >>> shift_i;
        clamped = shifted;
        if (relu_en_i && shifted[AccWidth-1]) begin
            clamped = '0;
        end
        if (clamped > SatMax) begin
            clamped = SatMax;
        end else if (clamped < SatMin) begin
            clamped = SatMin;
        end
        result_o = clamped[DataWidth-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/conv1d_par_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv1d_par_engine                                         |
// | Function : Sequential 1-D convolution engine sharing a single-port   |
// |            SRAM with a host bus; loads kernel, computes N-K+1        |
// |            outputs and writes them back.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module conv1d_par_engine
    import conv1d_par_pkg::*;
#(
    parameter int DataWidth  = DEF_DATA_WIDTH,
    parameter int MaxKernel  = DEF_MAX_KERNEL,
    parameter int NumWords   = DEF_NUM_WORDS,
    parameter int KernelBase = DEF_KERNEL_BASE,
    parameter int InBase     = MaxKernel,
    parameter int OutBase    = InBase + (NumWords - MaxKernel) / 2,
    localparam int AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [3:0]           klen_i,
    input  logic [AddrWidth-1:0] len_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_en_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i,
    output logic                 ext_gnt_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int KIdxWidth = (MaxKernel > 1) ? $clog2(MaxKernel) : 1;
    localparam logic [3:0]           MaxK   = 4'(MaxKernel);
    localparam logic [AddrWidth-1:0] MaxLen = AddrWidth'(OutBase - InBase);

    state_t                      state;
    state_t                      state_nxt;
    logic [3:0]                  cnt;
    logic [3:0]                  k_len;
    logic [AddrWidth-1:0]        idx;
    logic [AddrWidth-1:0]        n_len;
    logic [4:0]                  shift_amt;
    logic                        relu_en;
    logic                        err_flag;
    logic signed [DataWidth-1:0] weights [MaxKernel];
    logic                        cfg_ok;
    logic                        last_out;
    logic                        mac_clear;
    logic                        mac_en;
    logic [KIdxWidth-1:0]        widx;
    logic signed [DataWidth-1:0] sample;
    logic signed [DataWidth-1:0] result;
    logic                        unused_rdata_hi;

    // Configuration legality is judged on the live inputs at start
    assign cfg_ok = (klen_i != 4'd0) && (klen_i <= MaxK) &&
                    (len_i >= AddrWidth'(klen_i)) && (len_i <= MaxLen);

    assign last_out        = (idx == (n_len - AddrWidth'(k_len)));
    // Read data always belongs to the request issued one cycle earlier
    assign widx            = KIdxWidth'(cnt - 4'd1);
    assign sample          = $signed(mem_rdata_i[DataWidth-1:0]);
    assign unused_rdata_hi = ^mem_rdata_i[31:DataWidth];
    assign mem_wdata_o     = {{(32 - DataWidth){result[DataWidth-1]}}, result};
    assign err_o           = err_flag;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and SRAM/handshake outputs
    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        ext_gnt_o  = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                ext_gnt_o = 1'b1;
                if (start_i) begin
                    state_nxt = cfg_ok ? LOAD_K : DONE;
                end
            end
            LOAD_K: begin
                busy_o = 1'b1;
                if (cnt < k_len) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = AddrWidth'(KernelBase) + AddrWidth'(cnt);
                end
                if (cnt == k_len) begin
                    state_nxt = MAC;
                    mac_clear = 1'b1;
                end
            end
            MAC: begin
                busy_o = 1'b1;
                if (cnt < k_len) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = AddrWidth'(InBase) + idx + AddrWidth'(cnt);
                end
                mac_en = (cnt != 4'd0);
                if (cnt == k_len) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = AddrWidth'(OutBase) + idx;
                if (last_out) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = MAC;
                    mac_clear = 1'b1;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration capture, tap counter and output index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt       <= '0;
            idx       <= '0;
            k_len     <= '0;
            n_len     <= '0;
            shift_amt <= '0;
            relu_en   <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        k_len     <= klen_i;
                        n_len     <= len_i;
                        shift_amt <= shift_i;
                        relu_en   <= relu_en_i;
                        err_flag  <= !cfg_ok;
                        cnt       <= '0;
                        idx       <= '0;
                    end
                end
                LOAD_K, MAC: begin
                    cnt <= (cnt == k_len) ? 4'd0 : cnt + 4'd1;
                end
                WRITE: begin
                    cnt <= '0;
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Weight register file, filled one cycle behind each kernel read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < MaxKernel; j++) begin
                weights[j] <= '0;
            end
        end else if (state == LOAD_K && cnt != 4'd0) begin
            weights[widx] <= sample;
        end
    end

    conv1d_par_mac #(
        .DataWidth (DataWidth)
    ) u_mac (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (mac_clear),
        .acc_en_i  (mac_en),
        .sample_i  (sample),
        .weight_i  (weights[widx]),
        .shift_i   (shift_amt),
        .relu_en_i (relu_en),
        .result_o  (result)
    );

endmodule
`default_nettype wire

// File: tb/tb_conv1d_par_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_conv1d_par_engine                                      |
// | Function : Scoreboard bench for conv1d_par_engine with SRAM model    |
// |            and arithmetic reference model.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_conv1d_par_engine;
    localparam int NW = 128;
    localparam int AW = 7;
    localparam int MK = 8;
    localparam int KB = 0;
    localparam int IB = 8;
    localparam int OB = 68;

    typedef struct {int addr; logic [31:0] data;} wr_t;
    typedef struct {bit err; int busy;} dn_t;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [3:0]    klen_i;
    logic [AW-1:0] len_i;
    logic [4:0]    shift_i;
    logic          relu_en_i;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata = '0;
    logic          ext_gnt_o, busy_o, done_o, err_o;

    logic [31:0] mem [NW];
    wr_t wr_q[$];
    dn_t done_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  req_cnt  = 0;
    int  done_cnt = 0;
    int  n_writes = 0;
    int  busy_cnt = 0;
    wr_t mon_w;
    dn_t mon_d;

    conv1d_par_engine dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .klen_i      (klen_i),
        .len_i       (len_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata),
        .ext_gnt_o   (ext_gnt_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // SRAM: read data returned one cycle after the request
    always @(posedge clk) begin
        if (mem_req_o) begin
            req_cnt++;
            if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
            else          mem_rdata <= mem[mem_addr_o];
        end
    end

    // Monitor: pops the scoreboard on every write and every done pulse
    always @(negedge clk) begin
        if (!rst_ni) begin
            busy_cnt = 0;
        end else begin
            if (busy_o) begin
                busy_cnt++;
                n_checks++;
                if (ext_gnt_o) begin
                    n_errors++;
                    $display("FAIL gnt_while_busy: ext_gnt_o=%0b required 0", ext_gnt_o);
                end
            end
            if (ext_gnt_o) begin
                n_checks++;
                if (mem_req_o) begin
                    n_errors++;
                    $display("FAIL req_while_idle: mem_req_o=%0b required 0", mem_req_o);
                end
            end
            if (mem_req_o && mem_we_o) begin
                n_writes++;
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%0h required none", mem_addr_o, mem_wdata_o);
                end else begin
                    mon_w = wr_q.pop_front();
                    if (mem_addr_o !== AW'(mon_w.addr) || mem_wdata_o !== mon_w.data) begin
                        n_errors++;
                        $display("FAIL write: addr=%0d data=%0h required addr=%0d data=%0h",
                                 mem_addr_o, mem_wdata_o, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (done_o) begin
                done_cnt++;
                n_checks++;
                if (done_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: done_o=1 required 0");
                end else begin
                    mon_d = done_q.pop_front();
                    if (err_o !== mon_d.err || busy_cnt != mon_d.busy) begin
                        n_errors++;
                        $display("FAIL done: err=%0b busy=%0d required err=%0b busy=%0d",
                                 err_o, busy_cnt, mon_d.err, mon_d.busy);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic longint sval(input logic [31:0] w);
        return longint'($signed(w[15:0]));
    endfunction

    // Reference model: direct convolution sum from the memory image
    task automatic expect_run(input int k, input int n, input int sh, input bit relu);
        if (!(k >= 1 && k <= MK && n >= k && n <= OB - IB)) begin
            done_q.push_back('{1'b1, 0});
            return;
        end
        for (int i = 0; i <= n - k; i++) begin
            longint acc;
            acc = 0;
            for (int j = 0; j < k; j++) acc += sval(mem[IB + i + j]) * sval(mem[KB + j]);
            acc = acc >>> sh;
            if (relu && acc < 0) acc = 0;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            wr_q.push_back('{OB + i, 32'(acc)});
        end
        done_q.push_back('{1'b0, (k + 1) + (n - k + 1) * (k + 2)});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run(input int k, input int n, input int sh, input bit relu,
                       input bit disturb, output int reqs);
        int d0, r0, t;
        expect_run(k, n, sh, relu);
        d0 = done_cnt;
        r0 = req_cnt;
        @(negedge clk);
        klen_i = 4'(k); len_i = AW'(n); shift_i = 5'(sh); relu_en_i = relu; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        if (disturb) begin
            repeat ($urandom_range(1, 2)) @(negedge clk);
            start_i = 1'b1; klen_i = 4'($urandom); len_i = AW'($urandom);
            shift_i = 5'($urandom); relu_en_i = 1'($urandom);
            @(negedge clk);
            start_i = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("run_done_seen", 32'(done_cnt != d0), 32'd1);
        @(negedge clk);
        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        reqs = req_cnt - r0;
    endtask

    task automatic fill_random(input int k, input int n);
        for (int j = 0; j < k; j++) mem[KB + j] = $urandom;
        for (int i = 0; i < n; i++) mem[IB + i] = $urandom;
    endtask

    initial begin
        int reqs, w0, t, k, n;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        rst_ni = 1'b0; start_i = 1'b0; klen_i = '0; len_i = '0; shift_i = '0; relu_en_i = 1'b0;
        #3;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_gnt", 32'(ext_gnt_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Worked example: w={1,2,1}, x=1..8
        mem[0] = 1; mem[1] = 2; mem[2] = 1;
        for (int i = 0; i < 8; i++) mem[IB + i] = 32'(i + 1);
        run(3, 8, 0, 1'b0, 1'b0, reqs);
        for (int i = 0; i < 6; i++) check($sformatf("example_out%0d", i), mem[OB + i], 32'(8 + 4 * i));
        check("example_reqs", 32'(reqs), 32'd27);

        // Illegal configurations
        run(0, 8, 0, 1'b0, 1'b0, reqs);
        check("err_k0_reqs", 32'(reqs), 32'd0);
        check("err_sticky", 32'(err_o), 32'd1);
        run(4, 3, 0, 1'b0, 1'b0, reqs);
        check("err_k4n3_reqs", 32'(reqs), 32'd0);
        run(9, 20, 0, 1'b0, 1'b0, reqs);
        check("err_k9_reqs", 32'(reqs), 32'd0);
        run(2, 61, 0, 1'b0, 1'b0, reqs);
        check("err_n61_reqs", 32'(reqs), 32'd0);

        // Saturation, ReLU, floor shift, N=K single output
        for (int j = 0; j < 8; j++) begin mem[KB + j] = 32'h0000_7FFF; mem[IB + j] = 32'h0000_7FFF; end
        run(8, 8, 0, 1'b0, 1'b0, reqs);
        check("sat_pos", mem[OB], 32'h0000_7FFF);
        for (int j = 0; j < 8; j++) mem[KB + j] = 32'hABCD_8000;
        run(8, 8, 0, 1'b1, 1'b0, reqs);
        check("relu_zero", mem[OB], 32'h0000_0000);
        mem[KB] = 32'h0000_0001; mem[IB] = 32'hFFFF_FFF9;
        run(1, 1, 2, 1'b0, 1'b0, reqs);
        check("shift_floor", mem[OB], 32'hFFFF_FFFE);

        // Largest legal length
        fill_random(2, 60);
        run(2, 60, 10, 1'b0, 1'b0, reqs);

        // Randomised runs with ignored start pulses and config churn mid-run
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, MK);
            n = $urandom_range(k, k + 12);
            fill_random(k, n);
            run(k, n, $urandom_range(0, 24), 1'($urandom), 1'b1, reqs);
        end

        // Reset during MAC of output 3
        for (int i = 0; i < 6; i++) mem[OB + i] = 32'hDEAD_BEEF;
        fill_random(3, 8);
        expect_run(3, 8, 0, 1'b0);
        w0 = n_writes;
        @(negedge clk);
        klen_i = 4'd3; len_i = AW'(8); shift_i = '0; relu_en_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        t = 0;
        while (n_writes < w0 + 3 && t < 200) begin @(negedge clk); t++; end
        check("midrst_reached", 32'(n_writes - w0), 32'd3);
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_req", 32'(mem_req_o), 32'd0);
        check("midrst_we", 32'(mem_we_o), 32'd0);
        check("midrst_gnt", 32'(ext_gnt_o), 32'd1);
        wr_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (30) @(negedge clk);
        for (int i = 3; i < 6; i++) check($sformatf("midrst_unwritten%0d", i), mem[OB + i], 32'hDEAD_BEEF);
        check("midrst_no_writes", 32'(n_writes - w0), 32'd3);

        // Recovery after reset
        fill_random(4, 10);
        run(4, 10, 3, 1'b1, 1'b0, reqs);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
